// File: rtl/rf_write_queue.sv
// rtl/rf_write_queue.sv - writeback queue serializing ALU/load results onto the register file write port
module rf_write_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [3:0]       ld_dst,
    input  logic [15:0]      ld_data,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [3:0]       alu_dst,
    input  logic [15:0]      alu_data,
    input  logic             alu_wreg,
    input  logic [2:0]       alu_flag_en,
    input  logic [2:0]       alu_flags,
    output logic             rf_we,
    output logic [3:0]       rf_dst,
    output logic [15:0]      rf_data,
    output logic [2:0]       flag_en,
    output logic [2:0]       flag_val,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    output logic             pend1,
    output logic             pend2,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] depthVal = (PTR_W + 1)'(DEPTH);

    logic [3:0]       entDst  [DEPTH];
    logic [15:0]      entData [DEPTH];
    logic [2:0]       entFen  [DEPTH];
    logic [2:0]       entFval [DEPTH];
    logic [DEPTH-1:0] entWreg;
    logic [DEPTH-1:0] entValid;

    logic [PTR_W-1:0] headPtr, tailPtr, aluSlot;
    logic [PTR_W:0]   occ, freeSlots;
    logic             ldPush, aluPush, pop, headValid;
    logic             ldWreg, aluWreg;

    // Space is judged on the occupancy at cycle start; a same-cycle pop never helps.
    assign freeSlots = depthVal - occ;
    assign ld_ready  = (freeSlots >= (PTR_W + 1)'(1));
    assign alu_ready = (freeSlots >= (PTR_W + 1)'(2)) ||
                       ((freeSlots >= (PTR_W + 1)'(1)) && !ld_valid);

    assign ldPush  = ld_valid & ld_ready & !flush;
    assign aluPush = alu_valid & alu_ready & !flush;
    assign pop     = (occ != '0);
    assign aluSlot = tailPtr + PTR_W'(ldPush);

    // R0 is hardwired; only its flag side effects survive.
    assign ldWreg  = (ld_dst != 4'd0);
    assign aluWreg = alu_wreg & (alu_dst != 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            headPtr  <= '0;
            tailPtr  <= '0;
            occ      <= '0;
            entValid <= '0;
            entWreg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entDst[i]  <= '0;
                entData[i] <= '0;
                entFen[i]  <= '0;
                entFval[i] <= '0;
            end
        end else if (flush) begin
            headPtr  <= '0;
            tailPtr  <= '0;
            occ      <= '0;
            entValid <= '0;
        end else begin
            if (pop) begin
                entValid[headPtr] <= 1'b0;
                headPtr           <= headPtr + PTR_W'(1);
            end
            if (ldPush) begin
                entValid[tailPtr] <= 1'b1;
                entWreg[tailPtr]  <= ldWreg;
                entDst[tailPtr]   <= ld_dst;
                entData[tailPtr]  <= ld_data;
                entFen[tailPtr]   <= 3'b000;
                entFval[tailPtr]  <= 3'b000;
            end
            if (aluPush) begin
                entValid[aluSlot] <= 1'b1;
                entWreg[aluSlot]  <= aluWreg;
                entDst[aluSlot]   <= alu_dst;
                entData[aluSlot]  <= alu_data;
                entFen[aluSlot]   <= alu_flag_en;
                entFval[aluSlot]  <= alu_flags;
            end
            tailPtr <= tailPtr + PTR_W'(ldPush) + PTR_W'(aluPush);
            occ     <= occ + (PTR_W + 1)'(ldPush) + (PTR_W + 1)'(aluPush) - (PTR_W + 1)'(pop);
        end
    end

    assign headValid = entValid[headPtr];
    assign rf_we     = headValid & entWreg[headPtr];
    assign rf_dst    = headValid ? entDst[headPtr]  : 4'd0;
    assign rf_data   = headValid ? entData[headPtr] : 16'd0;
    assign flag_en   = headValid ? entFen[headPtr]  : 3'b000;
    assign flag_val  = headValid ? entFval[headPtr] : 3'b000;
    assign count     = occ;

    // The popping head still counts as pending; the register file resolves same-cycle read/write.
    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entValid[i] && entWreg[i] && (entDst[i] == src1) && (src1 != 4'd0)) pend1 = 1'b1;
            if (entValid[i] && entWreg[i] && (entDst[i] == src2) && (src2 != 4'd0)) pend2 = 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_write_queue.sv
// tb/tb_rf_write_queue.sv - directed and model-checked random bench for rf_write_queue
module tb_rf_write_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        ld_valid, ld_ready;
    logic [3:0]  ld_dst;
    logic [15:0] ld_data;
    logic        alu_valid, alu_ready;
    logic [3:0]  alu_dst;
    logic [15:0] alu_data;
    logic        alu_wreg;
    logic [2:0]  alu_flag_en, alu_flags;
    logic        rf_we;
    logic [3:0]  rf_dst;
    logic [15:0] rf_data;
    logic [2:0]  flag_en, flag_val;
    logic [3:0]  src1, src2;
    logic        pend1, pend2;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  dst;
        logic [15:0] data;
        logic        wreg;
        logic [2:0]  fen;
        logic [2:0]  fval;
    } entry_t;

    rf_write_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dst(ld_dst), .ld_data(ld_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst(alu_dst), .alu_data(alu_data),
        .alu_wreg(alu_wreg), .alu_flag_en(alu_flag_en), .alu_flags(alu_flags),
        .rf_we(rf_we), .rf_dst(rf_dst), .rf_data(rf_data), .flag_en(flag_en), .flag_val(flag_val),
        .src1(src1), .src2(src2), .pend1(pend1), .pend2(pend2), .count(count)
    );

    always #5 clk = ~clk;

    task automatic idle();
        flush = 0; ld_valid = 0; ld_dst = 0; ld_data = 0;
        alu_valid = 0; alu_dst = 0; alu_data = 0; alu_wreg = 0;
        alu_flag_en = 0; alu_flags = 0; src1 = 0; src2 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_pair(input logic [3:0] ld_d, input logic [3:0] alu_d);
        ld_valid = 1; ld_dst = ld_d; ld_data = {4{ld_d}};
        alu_valid = 1; alu_dst = alu_d; alu_data = {4{alu_d}}; alu_wreg = 1;
    endtask

    task automatic test_reset();
        #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%0d exp=0", rf_we); end
        total++; if (flag_en !== 3'b000) begin bad++; $display("FAIL reset_flag_en got=%b exp=000", flag_en); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if ({ld_ready, alu_ready} !== 2'b11) begin bad++; $display("FAIL reset_ready got=%b exp=11", {ld_ready, alu_ready}); end
        total++; if ({pend1, pend2} !== 2'b00) begin bad++; $display("FAIL reset_pend got=%b exp=00", {pend1, pend2}); end
    endtask

    task automatic test_single_alu();
        alu_valid = 1; alu_dst = 3; alu_data = 16'hBEEF; alu_wreg = 1;
        alu_flag_en = 3'b100; alu_flags = 3'b100;
        #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL single_nobypass got=%0d exp=0", rf_we); end
        tick(); idle(); #1;
        total++; if ({rf_we, rf_dst, rf_data} !== {1'b1, 4'd3, 16'hBEEF}) begin bad++; $display("FAIL single_write got=%b/%0d/%h exp=1/3/beef", rf_we, rf_dst, rf_data); end
        total++; if ({flag_en, flag_val} !== 6'b100_100) begin bad++; $display("FAIL single_flags got=%b/%b exp=100/100", flag_en, flag_val); end
        tick(); #1;
        total++; if ({rf_we, count} !== {1'b0, 3'd0}) begin bad++; $display("FAIL single_drain got=%0d/%0d exp=0/0", rf_we, count); end
    endtask

    task automatic test_simultaneous();
        ld_valid = 1; ld_dst = 5; ld_data = 16'h1111;
        alu_valid = 1; alu_dst = 6; alu_data = 16'h2222; alu_wreg = 1;
        tick(); idle(); #1;
        total++; if ({rf_we, rf_dst, rf_data, count} !== {1'b1, 4'd5, 16'h1111, 3'd2}) begin bad++; $display("FAIL simul_first got=%0d/%0d/%h/%0d exp=1/5/1111/2", rf_we, rf_dst, rf_data, count); end
        tick(); #1;
        total++; if ({rf_we, rf_dst, rf_data, count} !== {1'b1, 4'd6, 16'h2222, 3'd1}) begin bad++; $display("FAIL simul_second got=%0d/%0d/%h/%0d exp=1/6/2222/1", rf_we, rf_dst, rf_data, count); end
        tick(); #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL simul_empty got=%0d exp=0", count); end
    endtask

    task automatic test_fill();
        push_pair(1, 2);
        tick(); #1;
        total++; if (count !== 3'd2) begin bad++; $display("FAIL fill_c2 got=%0d exp=2", count); end
        push_pair(3, 4); #1;
        total++; if ({ld_ready, alu_ready} !== 2'b11) begin bad++; $display("FAIL fill_ready2 got=%b exp=11", {ld_ready, alu_ready}); end
        tick(); #1;
        total++; if (count !== 3'd3) begin bad++; $display("FAIL fill_c3 got=%0d exp=3", count); end
        push_pair(5, 6); #1;
        total++; if ({ld_ready, alu_ready} !== 2'b10) begin bad++; $display("FAIL fill_ready1 got=%b exp=10", {ld_ready, alu_ready}); end
        ld_valid = 0; #1;
        total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL fill_alu_alone got=%0d exp=1", alu_ready); end
        ld_valid = 1; tick(); idle(); #1;
        total++; if ({count, rf_dst} !== {3'd3, 4'd3}) begin bad++; $display("FAIL fill_steady got=%0d/%0d exp=3/3", count, rf_dst); end
        repeat (3) tick();
        #1;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL fill_drain got=%0d exp=0", count); end
    endtask

    task automatic test_r0_flags();
        alu_valid = 1; alu_dst = 0; alu_data = 16'hFFFF; alu_wreg = 1;
        alu_flag_en = 3'b010; alu_flags = 3'b010;
        tick(); idle(); #1;
        total++; if ({rf_we, flag_en, flag_val} !== {1'b0, 3'b010, 3'b010}) begin bad++; $display("FAIL r0_flags got=%0d/%b/%b exp=0/010/010", rf_we, flag_en, flag_val); end
        total++; if (pend1 !== 1'b0) begin bad++; $display("FAIL r0_pend got=%0d exp=0", pend1); end
        tick();
    endtask

    task automatic test_hazard();
        push_pair(7, 9); src1 = 7; src2 = 9; #1;
        total++; if ({pend1, pend2} !== 2'b00) begin bad++; $display("FAIL haz_enq got=%b exp=00", {pend1, pend2}); end
        tick(); idle(); src1 = 7; src2 = 9; #1;
        total++; if ({pend1, pend2} !== 2'b11) begin bad++; $display("FAIL haz_both got=%b exp=11", {pend1, pend2}); end
        tick(); #1;
        total++; if ({pend1, pend2} !== 2'b01) begin bad++; $display("FAIL haz_one got=%b exp=01", {pend1, pend2}); end
        tick(); #1;
        total++; if ({pend1, pend2} !== 2'b00) begin bad++; $display("FAIL haz_none got=%b exp=00", {pend1, pend2}); end
        idle();
    endtask

    task automatic test_flush_reset();
        push_pair(1, 2); tick();
        push_pair(3, 4); tick(); idle();
        flush = 1; alu_valid = 1; alu_dst = 12; alu_data = 16'hCCCC; alu_wreg = 1; #1;
        total++; if ({rf_we, rf_dst} !== {1'b1, 4'd2}) begin bad++; $display("FAIL flush_head got=%0d/%0d exp=1/2", rf_we, rf_dst); end
        tick(); idle(); #1;
        total++; if ({rf_we, count} !== {1'b0, 3'd0}) begin bad++; $display("FAIL flush_clear got=%0d/%0d exp=0/0", rf_we, count); end
        tick(); #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL flush_dropped got=%0d exp=0", rf_we); end
        push_pair(8, 10); tick(); idle(); #1;
        total++; if ({rf_we, count} !== {1'b1, 3'd2}) begin bad++; $display("FAIL rst_pre got=%0d/%0d exp=1/2", rf_we, count); end
        rst_n = 0; #1;
        total++; if ({rf_we, count} !== {1'b0, 3'd0}) begin bad++; $display("FAIL rst_async got=%0d/%0d exp=0/0", rf_we, count); end
        tick(); rst_n = 1; tick(); #1;
        total++; if ({rf_we, count} !== {1'b0, 3'd0}) begin bad++; $display("FAIL rst_after got=%0d/%0d exp=0/0", rf_we, count); end
    endtask

    task automatic test_random();
        entry_t q[$];
        entry_t e;
        logic   expLdRdy, expAluRdy, expP1, expP2, ldAcc, aluAcc;
        int     freeN;
        for (int cyc = 0; cyc < 400; cyc++) begin
            flush       = ($urandom_range(0, 24) == 0);
            ld_valid    = $urandom_range(0, 1);
            ld_dst      = 4'($urandom_range(0, 15));
            ld_data     = 16'($urandom);
            alu_valid   = $urandom_range(0, 1);
            alu_dst     = 4'($urandom_range(0, 15));
            alu_data    = 16'($urandom);
            alu_wreg    = $urandom_range(0, 1);
            alu_flag_en = 3'($urandom_range(0, 7));
            alu_flags   = 3'($urandom_range(0, 7));
            src1        = 4'($urandom_range(0, 15));
            src2        = 4'($urandom_range(0, 15));
            #1;
            freeN     = 4 - q.size();
            expLdRdy  = (freeN >= 1);
            expAluRdy = (freeN >= 2) || (freeN >= 1 && !ld_valid);
            expP1 = 0; expP2 = 0;
            foreach (q[i]) begin
                if (q[i].wreg && q[i].dst == src1 && src1 != 0) expP1 = 1;
                if (q[i].wreg && q[i].dst == src2 && src2 != 0) expP2 = 1;
            end
            total++; if (count !== 3'(q.size())) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", cyc, count, q.size()); end
            total++; if ({ld_ready, alu_ready} !== {expLdRdy, expAluRdy}) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", cyc, {ld_ready, alu_ready}, {expLdRdy, expAluRdy}); end
            total++; if ({pend1, pend2} !== {expP1, expP2}) begin bad++; $display("FAIL rnd_pend c=%0d got=%b exp=%b", cyc, {pend1, pend2}, {expP1, expP2}); end
            if (q.size() == 0) begin
                total++; if ({rf_we, flag_en} !== 4'b0) begin bad++; $display("FAIL rnd_idle c=%0d got=%0d/%b exp=0/000", cyc, rf_we, flag_en); end
            end else begin
                e = q[0];
                total++; if ({rf_we, flag_en} !== {e.wreg, e.fen}) begin bad++; $display("FAIL rnd_en c=%0d got=%0d/%b exp=%0d/%b", cyc, rf_we, flag_en, e.wreg, e.fen); end
                if (e.wreg) begin
                    total++; if ({rf_dst, rf_data} !== {e.dst, e.data}) begin bad++; $display("FAIL rnd_data c=%0d got=%0d/%h exp=%0d/%h", cyc, rf_dst, rf_data, e.dst, e.data); end
                end
                if (e.fen != 0) begin
                    total++; if (flag_val !== e.fval) begin bad++; $display("FAIL rnd_fval c=%0d got=%b exp=%b", cyc, flag_val, e.fval); end
                end
            end
            ldAcc  = ld_valid && expLdRdy && !flush;
            aluAcc = alu_valid && expAluRdy && !flush;
            tick();
            if (flush) q.delete();
            else begin
                if (q.size() > 0) void'(q.pop_front());
                if (ldAcc) q.push_back('{dst: ld_dst, data: ld_data, wreg: (ld_dst != 0), fen: 3'b000, fval: 3'b000});
                if (aluAcc) q.push_back('{dst: alu_dst, data: alu_data, wreg: alu_wreg && (alu_dst != 0), fen: alu_flag_en, fval: alu_flags});
            end
        end
        idle();
    endtask

    initial begin
        rst_n = 0;
        idle();
        tick();
        test_reset();
        rst_n = 1;
        tick();
        test_single_alu();
        test_simultaneous();
        test_fill();
        test_r0_flags();
        test_hazard();
        test_flush_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
